spi_cfg_sequencer: RTL and testbench
====================================

// Module: spi_cfg_sequencer
// PURPOSE
//  Upstream feeder for the SPI frame serializer. Walks a synchronous init ROM of 24-bit entries ({addr[15:0], data[7:0]}).
//  Presents each write entry to the serializer over a valid/ready handshake and waits for frame completion.
//  Honours a programmable inter-frame gap and in-table delay/end markers. Raises done or error when the walk ends.
// PARAMETERS
//  NUM_ENTRIES  368      ROM depth; walk ends at NUM_ENTRIES if no end marker is found
//  ADDR_W       9        ROM address width; must satisfy 2**ADDR_W >= NUM_ENTRIES
//  GAP_CYCLES   4        idle clk cycles between frame_done and the next fetch (0 allowed)
//  DELAY_UNIT   1000     clk cycles per unit of a delay entry's data byte
//  TIMEOUT      4096     max clk cycles from handshake to frame_done before error
// PORTS
//  clk           in   1       system clock
//  reset         in   1       asynchronous, active-high
//  start         in   1       1-cycle pulse; begins a walk from entry 0 (ignored while busy)
//  rom_addr      out  ADDR_W  ROM read address
//  rom_data      in   24      ROM data, valid 1 clk after rom_addr
//  word_data     out  24      entry presented to the serializer
//  word_valid    out  1       word_data valid
//  word_ready    in   1       serializer accepts word (transfer = valid & ready)
//  frame_done    in   1       1-cycle pulse when the serializer finishes a frame (cs_l deasserted)
//  busy          out  1       walk in progress
//  done          out  1       sticky; walk completed OK, cleared by next accepted start
//  error         out  1       sticky; timeout occurred, cleared by next accepted start
//  words_sent    out  ADDR_W+1  count of frames completed in the current/last walk
// BEHAVIOUR
//  Reset (async): state IDLE, rom_addr=0, word_data=0, word_valid=0, busy=0, done=0, error=0, words_sent=0.
//  States: IDLE, FETCH, DECODE, SEND, WAIT_DONE, GAP, DELAY, FINISH, ERROR.
//  IDLE: start=1 -> clear done/error/words_sent; set idx=0 and busy=1; go to FETCH.
//  FETCH: drive rom_addr=idx for 1 cycle; go to DECODE. rom_data is sampled in DECODE.
//  DECODE: decode by rom_data[23:8]:
//   - 16'hFFFE (end marker) -> FINISH.
//   - 16'hFFFF (delay) -> load delay counter = rom_data[7:0]*DELAY_UNIT; go to DELAY. Data 0 = no wait; advance next cycle.
//   - otherwise -> latch word_data=rom_data, word_valid=1, go to SEND.
//  SEND: hold word_data/word_valid stable until word_ready=1. On that cycle, drop word_valid next clk,
//   load timeout counter = TIMEOUT, and go to WAIT_DONE. No timeout applies while waiting for ready.
//  WAIT_DONE: frame_done=1 -> words_sent++, go to GAP.
//   Timeout counter reaching 0 with no frame_done -> error=1, go to ERROR.
//   A frame_done outside WAIT_DONE is ignored.
//  GAP: count GAP_CYCLES (0 = skip), then advance.
//  DELAY: count down to 0, then advance.
//  Advance: idx++. If idx == NUM_ENTRIES -> FINISH, else -> FETCH. The index never wraps.
//  FINISH: done=1, busy=0 -> IDLE.
//  ERROR: busy=0, word_valid=0 -> IDLE. error remains set until the next start.
//  start while busy is ignored, including in the same cycle as FINISH/ERROR. A restart needs a fresh pulse in IDLE.
//  Reset mid-walk aborts immediately: word_valid drops asynchronously and nothing else is sent.
//  Delay counter width covers 255*DELAY_UNIT. Timeout counter width covers TIMEOUT.
//  Latency: start -> first word_valid = 3 clks (IDLE->FETCH->DECODE->SEND).
// TESTING
//  1. ROM = {0x00120A, 0x003455, 0xFFFE00}; start; ready tied 1; frame_done 10 clks after each handshake
//     -> exactly 2 words sent in order (0x00120A, 0x003455); words_sent=2; done=1; busy=0.
//  2. Hold word_ready=0 for 20 clks while word_valid=1
//     -> word_data stable throughout, no error; transfer completes when ready rises.
//  3. Entry 0xFFFF03 with DELAY_UNIT=10 -> next word_valid appears no sooner than 30 clks
//     after the delay entry is decoded; delay entry is not sent and not counted.
//  4. Never pulse frame_done after a handshake -> error=1 after TIMEOUT clks; busy=0;
//     next start clears error and restarts from entry 0.
//  5. ROM with no end marker, NUM_ENTRIES=4 -> 4 words sent, done=1, rom_addr never exceeds 3.
//  6. Assert reset during SEND -> all outputs return to reset values immediately;
//     start pulses while busy have no effect.

Source files
------------

// File: rtl/spi_cfg_sequencer.sv
// Init-ROM walker feeding the SPI frame serializer: fetches {addr,data} entries, hands write
// entries over valid/ready, waits for frame completion, and honours gap, delay and end markers.
module spi_cfg_sequencer #(
    parameter int NUM_ENTRIES = 368,
    parameter int ADDR_W      = 9,
    parameter int GAP_CYCLES  = 4,
    parameter int DELAY_UNIT  = 1000,
    parameter int TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [23:0]       word_data,
    output logic              word_valid,
    input  logic              word_ready,
    input  logic              frame_done,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_sent
);

    // state     | meaning
    // IDLE      | waiting for start
    // FETCH     | rom_addr presented to the ROM
    // DECODE    | rom_data sampled and classified
    // SEND      | word_valid held until word_ready
    // WAIT_DONE | waiting for frame_done, timeout running
    // GAP       | inter-frame idle
    // DELAY     | in-table delay countdown
    // FINISH    | walk completed, raise done
    // ERROR     | timeout, abandon walk
    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, SEND, WAIT_DONE, GAP, DELAY, FINISH, ERROR
    } state_t;

    localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int MX1_W = (DLY_W > TMO_W) ? DLY_W : TMO_W;
    localparam int MX2_W = (MX1_W > GAP_W) ? MX1_W : GAP_W;
    localparam int CNT_W = (MX2_W > 0) ? MX2_W : 1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_entry;

    // rom_addr doubles as the walk index; it only advances when another entry exists
    assign last_entry = (rom_addr == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rom_addr   <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done       <= 1'b0;
                        error      <= 1'b0;
                        words_sent <= '0;
                        rom_addr   <= '0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (rom_data[23:8] == 16'hFFFE) begin
                        state <= FINISH;
                    end else if (rom_data[23:8] == 16'hFFFF) begin
                        cnt   <= CNT_W'(rom_data[7:0]) * CNT_W'(DELAY_UNIT);
                        state <= DELAY;
                    end else begin
                        word_data  <= rom_data;
                        word_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        cnt        <= CNT_W'(TIMEOUT);
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (frame_done) begin
                        words_sent <= words_sent + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            cnt   <= GAP_LOAD;
                            state <= GAP;
                        end else if (last_entry) begin
                            state <= FINISH;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end else if (cnt == '0) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP, DELAY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (last_entry) begin
                        state <= FINISH;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= FETCH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERROR: begin
                    busy       <= 1'b0;
                    word_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer: TB-side synchronous ROM and a serializer model
// that answers each handshake with frame_done 10 clocks later.
module tb_spi_cfg_sequencer;

    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data = '0;
    logic [23:0]       word_data;
    logic              word_valid;
    logic              word_ready = 1'b0;
    logic              frame_done = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_sent;

    int total = 0;
    int bad   = 0;

    logic [23:0] rom [0:7];
    logic [23:0] sent_log [0:15];
    int          n_log = 0;
    int          fd_cnt = 0;
    logic        fd_en = 1'b1;
    int          max_addr = 0;

    spi_cfg_sequencer #(
        .NUM_ENTRIES(4), .ADDR_W(ADDR_W), .GAP_CYCLES(4), .DELAY_UNIT(10), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .frame_done(frame_done), .busy(busy), .done(done), .error(error),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // serializer model; samples at negedge, the handshake happens on the following posedge
    always @(negedge clk) begin
        frame_done = 1'b0;
        if (reset) begin
            fd_cnt = 0;
        end else begin
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
            if (fd_cnt > 0) begin
                fd_cnt = fd_cnt - 1;
                if (fd_cnt == 0) frame_done = 1'b1;
            end
            if (word_valid && word_ready) begin
                if (n_log < 16) sent_log[n_log] = word_data;
                n_log = n_log + 1;
                if (fd_en) fd_cnt = 10;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (word_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic load_rom(input logic [23:0] e0, e1, e2, e3);
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
        for (int i = 4; i < 8; i++) rom[i] = 24'h00EEEE;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++; if (rom_addr !== 3'd0) begin bad++; $display("FAIL reset_rom_addr got=%0h exp=0", rom_addr); end
        total++; if (word_data !== 24'd0) begin bad++; $display("FAIL reset_word_data got=%0h exp=0", word_data); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
        total++; if (words_sent !== 4'd0) begin bad++; $display("FAIL reset_words_sent got=%0d exp=0", words_sent); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        load_rom(24'h00120A, 24'h003455, 24'hFFFE00, 24'h00EEEE);
        n_log = 0; fd_en = 1'b1; word_ready = 1'b1;
        pulse_start();
        tick(); tick();
        total++; if (word_valid !== 1'b1 || word_data !== 24'h00120A) begin
            bad++; $display("FAIL basic_latency got valid=%b data=%0h exp valid=1 data=00120a", word_valid, word_data);
        end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_idle_timeout got=busy exp=idle"); end
        total++; if (n_log !== 2) begin bad++; $display("FAIL basic_count got=%0d exp=2", n_log); end
        total++; if (sent_log[0] !== 24'h00120A) begin bad++; $display("FAIL basic_word0 got=%0h exp=00120a", sent_log[0]); end
        total++; if (sent_log[1] !== 24'h003455) begin bad++; $display("FAIL basic_word1 got=%0h exp=003455", sent_log[1]); end
        total++; if (words_sent !== 4'd2) begin bad++; $display("FAIL basic_words_sent got=%0d exp=2", words_sent); end
        total++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            bad++; $display("FAIL basic_flags got done=%b busy=%b error=%b exp 1 0 0", done, busy, error);
        end
    endtask

    task automatic test_ready_stall();
        bit ok;
        bit stable;
        load_rom(24'h00AB11, 24'hFFFE00, 24'h00EEEE, 24'h00EEEE);
        n_log = 0; fd_en = 1'b1; word_ready = 1'b0;
        pulse_start();
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_valid_timeout got=0 exp=1"); end
        // stall longer than TIMEOUT: the timeout must not run while waiting for ready
        stable = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (word_valid !== 1'b1 || word_data !== 24'h00AB11 || error !== 1'b0) stable = 1'b0;
        end
        total++; if (!stable) begin
            bad++; $display("FAIL stall_hold got valid=%b data=%0h error=%b exp 1 00ab11 0", word_valid, word_data, error);
        end
        total++; if (n_log !== 0) begin bad++; $display("FAIL stall_no_transfer got=%0d exp=0", n_log); end
        word_ready = 1'b1;
        wait_idle(ok);
        total++; if (n_log !== 1 || sent_log[0] !== 24'h00AB11) begin
            bad++; $display("FAIL stall_transfer got n=%0d w=%0h exp n=1 w=00ab11", n_log, sent_log[0]);
        end
        total++; if (done !== 1'b1 || error !== 1'b0) begin
            bad++; $display("FAIL stall_flags got done=%b error=%b exp 1 0", done, error);
        end
    endtask

    task automatic test_delay();
        bit ok;
        int k;
        load_rom(24'h001101, 24'hFFFF03, 24'hFFFF00, 24'h002202);
        n_log = 0; fd_en = 1'b1; word_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (word_valid && word_ready) begin ok = 1'b1; break; end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL delay_first_hs got=0 exp=1"); end
        // frame 10 + gap 4 + delay 3*10 is the minimum before the next word can appear
        k = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            k++;
            if (word_valid) begin ok = 1'b1; break; end
        end
        total++; if (!ok || k < 44 || k > 60) begin
            bad++; $display("FAIL delay_spacing got=%0d exp=44..60", k);
        end
        wait_idle(ok);
        total++; if (n_log !== 2 || sent_log[1] !== 24'h002202) begin
            bad++; $display("FAIL delay_words got n=%0d w1=%0h exp n=2 w1=002202", n_log, sent_log[1]);
        end
        total++; if (words_sent !== 4'd2 || done !== 1'b1) begin
            bad++; $display("FAIL delay_count got ws=%0d done=%b exp 2 1", words_sent, done);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        load_rom(24'h003301, 24'hFFFE00, 24'h00EEEE, 24'h00EEEE);
        n_log = 0; fd_en = 1'b0; word_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (word_valid && word_ready) begin ok = 1'b1; break; end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL timeout_hs got=0 exp=1"); end
        k = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            k++;
            if (error) begin ok = 1'b1; break; end
        end
        total++; if (!ok || k < 64 || k > 70) begin bad++; $display("FAIL timeout_latency got=%0d exp=64..70", k); end
        tick(); tick();
        total++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b1 || word_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_flags got busy=%b done=%b error=%b valid=%b exp 0 0 1 0", busy, done, error, word_valid);
        end
        total++; if (words_sent !== 4'd0) begin bad++; $display("FAIL timeout_words_sent got=%0d exp=0", words_sent); end
        fd_en = 1'b1; n_log = 0;
        pulse_start();
        total++; if (error !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL timeout_restart_clear got error=%b busy=%b exp 0 1", error, busy);
        end
        wait_idle(ok);
        total++; if (n_log !== 1 || sent_log[0] !== 24'h003301 || done !== 1'b1) begin
            bad++; $display("FAIL timeout_restart got n=%0d w=%0h done=%b exp 1 003301 1", n_log, sent_log[0], done);
        end
    endtask

    task automatic test_no_end();
        bit ok;
        load_rom(24'h000001, 24'h000002, 24'h000003, 24'h000004);
        n_log = 0; fd_en = 1'b1; word_ready = 1'b1; max_addr = 0;
        pulse_start();
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL noend_idle_timeout got=busy exp=idle"); end
        total++; if (n_log !== 4 || sent_log[3] !== 24'h000004) begin
            bad++; $display("FAIL noend_words got n=%0d w3=%0h exp 4 000004", n_log, sent_log[3]);
        end
        total++; if (words_sent !== 4'd4 || done !== 1'b1) begin
            bad++; $display("FAIL noend_count got ws=%0d done=%b exp 4 1", words_sent, done);
        end
        total++; if (max_addr > 3) begin bad++; $display("FAIL noend_rom_addr got=%0d exp<=3", max_addr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        load_rom(24'h004401, 24'hFFFE00, 24'h00EEEE, 24'h00EEEE);
        n_log = 0; fd_en = 1'b1; word_ready = 1'b0;
        pulse_start();
        wait_valid(ok);
        pulse_start();
        pulse_start();
        total++; if (word_valid !== 1'b1 || word_data !== 24'h004401 || busy !== 1'b1) begin
            bad++; $display("FAIL busy_start_ignored got valid=%b data=%0h busy=%b exp 1 004401 1", word_valid, word_data, busy);
        end
        word_ready = 1'b1;
        wait_idle(ok);
        total++; if (n_log !== 1 || words_sent !== 4'd1 || done !== 1'b1) begin
            bad++; $display("FAIL busy_start_walk got n=%0d ws=%0d done=%b exp 1 1 1", n_log, words_sent, done);
        end
        n_log = 0; word_ready = 1'b0;
        pulse_start();
        wait_valid(ok);
        #2 reset = 1'b1;
        #1;
        total++; if (word_valid !== 1'b0 || word_data !== 24'd0 || busy !== 1'b0 || rom_addr !== 3'd0) begin
            bad++; $display("FAIL async_reset got valid=%b data=%0h busy=%b addr=%0d exp 0 0 0 0", word_valid, word_data, busy, rom_addr);
        end
        total++; if (done !== 1'b0 || error !== 1'b0 || words_sent !== 4'd0) begin
            bad++; $display("FAIL async_reset_flags got done=%b error=%b ws=%0d exp 0 0 0", done, error, words_sent);
        end
        tick(); tick();
        reset = 1'b0;
        word_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        total++; if (n_log !== 0 || word_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_abort got n=%0d valid=%b busy=%b exp 0 0 0", n_log, word_valid, busy);
        end
    endtask

    initial begin
        load_rom(24'h00EEEE, 24'h00EEEE, 24'h00EEEE, 24'h00EEEE);
        test_reset();
        test_basic();
        test_ready_stall();
        test_delay();
        test_timeout();
        test_no_end();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
